// File: rtl/data_sram_bridge.sv
// Bridges the pipeline's single-cycle data SRAM port onto a request/response bus.
// Holds one transaction at a time and stalls the EX stage until it completes.
module data_sram_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic        is_write;
    logic [31:0] rdata_q;

    // The bus fields are the captured request; they are zeroed once the bus takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            rdata_q   <= 32'd0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_be    <= 4'd0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_sram_en && !flush) begin
                        state     <= REQ;
                        is_write  <= |data_sram_wen;
                        bus_req   <= 1'b1;
                        bus_wr    <= |data_sram_wen;
                        bus_be    <= (|data_sram_wen) ? data_sram_wen : 4'hF;
                        bus_addr  <= data_sram_addr & 32'hFFFF_FFFC;
                        bus_wdata <= data_sram_wdata;
                    end
                end
                REQ: begin
                    // Acceptance takes priority over a flush arriving in the same cycle.
                    if (bus_ready || flush) begin
                        state     <= bus_ready ? WAIT : IDLE;
                        bus_req   <= 1'b0;
                        bus_wr    <= 1'b0;
                        bus_be    <= 4'd0;
                        bus_addr  <= 32'd0;
                        bus_wdata <= 32'd0;
                    end
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        state <= DONE;
                        if (!is_write) begin
                            rdata_q <= bus_rdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign stallreq = ((state == IDLE) && data_sram_en && !flush)
                    || (state == REQ) || (state == WAIT);

    assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed self-checking bench for data_sram_bridge: read, write, backpressure,
// flush in REQ, flush racing acceptance, and reset abandoning a transaction.
module tb_data_sram_bridge;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int checks_done;
    int checks_failed;

    data_sram_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq        (stallreq),
        .bus_req         (bus_req),
        .bus_wr          (bus_wr),
        .bus_be          (bus_be),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_ready       (bus_ready),
        .bus_rvalid      (bus_rvalid),
        .bus_rdata       (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] wen,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic fl);
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        flush           = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_done++;
        if (observed !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkBusIdle(input string tag);
        checkOutput({tag, " bus_req"}, {31'd0, bus_req}, 32'd0);
    endtask

    initial begin
        checks_done   = 0;
        checks_failed = 0;
        rst        = 1'b1;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

        // Reset state
        tick();
        tick();
        checkOutput("rst bus_req",   {31'd0, bus_req}, 32'd0);
        checkOutput("rst bus_wr",    {31'd0, bus_wr},  32'd0);
        checkOutput("rst bus_be",    {28'd0, bus_be},  32'd0);
        checkOutput("rst bus_addr",  bus_addr,         32'd0);
        checkOutput("rst bus_wdata", bus_wdata,        32'd0);
        checkOutput("rst rdata",     data_sram_rdata,  32'd0);
        checkOutput("rst stall en0", {31'd0, stallreq}, 32'd0);
        applyStimulus(1'b1, 4'd0, 32'h1000, 32'd0, 1'b0);
        checkOutput("rst stall en1", {31'd0, stallreq}, 32'd1);
        tick();
        checkOutput("rst holds idle", {31'd0, bus_req}, 32'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        rst = 1'b0;
        tick();

        // Read of a misaligned address, ready and rvalid on first chance
        $display("[TB] read");
        bus_ready = 1'b1;
        applyStimulus(1'b1, 4'b0000, 32'h0000_1006, 32'd0, 1'b0);
        checkOutput("rd stall idle", {31'd0, stallreq}, 32'd1);
        tick();
        checkOutput("rd bus_req",  {31'd0, bus_req}, 32'd1);
        checkOutput("rd bus_addr", bus_addr,         32'h0000_1004);
        checkOutput("rd bus_be",   {28'd0, bus_be},  32'h0000_000F);
        checkOutput("rd bus_wr",   {31'd0, bus_wr},  32'd0);
        checkOutput("rd stall req", {31'd0, stallreq}, 32'd1);
        tick();
        checkOutput("rd wait bus_req", {31'd0, bus_req}, 32'd0);
        checkOutput("rd stall wait",   {31'd0, stallreq}, 32'd1);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEAD_BEEF;
        tick();
        bus_rvalid = 1'b0;
        checkOutput("rd stall done", {31'd0, stallreq}, 32'd0);
        checkOutput("rd rdata",      data_sram_rdata,   32'hDEAD_BEEF);
        tick();
        checkOutput("done ignores en", {31'd0, bus_req}, 32'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("rd idle stall", {31'd0, stallreq}, 32'd0);

        // Write: bus sees the byte enables, read data is untouched
        $display("[TB] write");
        applyStimulus(1'b1, 4'b0011, 32'h0000_0020, 32'h0000_ABCD, 1'b0);
        tick();
        checkOutput("wr bus_wr",    {31'd0, bus_wr},  32'd1);
        checkOutput("wr bus_be",    {28'd0, bus_be},  32'h0000_0003);
        checkOutput("wr bus_addr",  bus_addr,         32'h0000_0020);
        checkOutput("wr bus_wdata", bus_wdata,        32'h0000_ABCD);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        tick();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h5555_5555;
        tick();
        bus_rvalid = 1'b0;
        checkOutput("wr rdata kept", data_sram_rdata, 32'hDEAD_BEEF);
        tick();

        // Backpressure for 5 cycles with a stray rvalid that must be ignored
        $display("[TB] backpressure");
        bus_ready = 1'b0;
        applyStimulus(1'b1, 4'b1100, 32'h1000_0003, 32'h1234_0000, 1'b0);
        tick();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h0000_0BAD;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp bus_req",   {31'd0, bus_req},  32'd1);
            checkOutput("bp bus_addr",  bus_addr,          32'h1000_0000);
            checkOutput("bp bus_be",    {28'd0, bus_be},   32'h0000_000C);
            checkOutput("bp bus_wr",    {31'd0, bus_wr},   32'd1);
            checkOutput("bp bus_wdata", bus_wdata,         32'h1234_0000);
            checkOutput("bp stallreq",  {31'd0, stallreq}, 32'd1);
            tick();
        end
        bus_rvalid = 1'b0;
        bus_ready  = 1'b1;
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        tick();
        bus_ready = 1'b0;
        checkOutput("bp accepted", {31'd0, bus_req}, 32'd0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        tick();
        checkOutput("wait ignores flush", {31'd0, stallreq}, 32'd1);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        bus_rvalid = 1'b1;
        tick();
        bus_rvalid = 1'b0;
        checkOutput("bp done stall", {31'd0, stallreq}, 32'd0);
        checkOutput("bp rdata kept", data_sram_rdata,   32'hDEAD_BEEF);
        tick();

        // Flush in REQ with ready low cancels the request
        $display("[TB] flush in req");
        applyStimulus(1'b1, 4'b0000, 32'h0000_0040, 32'd0, 1'b0);
        tick();
        checkOutput("fl in req", {31'd0, bus_req}, 32'd1);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        tick();
        checkBusIdle("fl cancel");
        checkOutput("fl stallreq", {31'd0, stallreq}, 32'd0);
        applyStimulus(1'b1, 4'd0, 32'h0000_0040, 32'd0, 1'b1);
        checkOutput("fl idle stall", {31'd0, stallreq}, 32'd0);
        bus_ready = 1'b1;
        tick();
        checkBusIdle("fl no txn");
        checkOutput("fl no stall", {31'd0, stallreq}, 32'd0);
        bus_ready = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

        // Flush and ready together in REQ: acceptance wins
        $display("[TB] flush with ready");
        applyStimulus(1'b1, 4'b0000, 32'h0000_0084, 32'd0, 1'b0);
        tick();
        bus_ready = 1'b1;
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        tick();
        checkOutput("flr in wait", {31'd0, stallreq}, 32'd1);
        checkBusIdle("flr accepted");
        bus_ready = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hCAFE_F00D;
        tick();
        bus_rvalid = 1'b0;
        checkOutput("flr rdata", data_sram_rdata,   32'hCAFE_F00D);
        checkOutput("flr done",  {31'd0, stallreq}, 32'd0);
        tick();

        // Reset in WAIT abandons the transaction; a later rvalid is ignored
        $display("[TB] reset in wait");
        bus_ready = 1'b1;
        applyStimulus(1'b1, 4'b0000, 32'h0000_0100, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        tick();
        bus_ready = 1'b0;
        checkOutput("rw in wait", {31'd0, stallreq}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rw rdata cleared", data_sram_rdata, 32'd0);
        checkOutput("rw stall", {31'd0, stallreq}, 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h0000_1234;
        tick();
        bus_rvalid = 1'b0;
        checkOutput("rw stray rdata", data_sram_rdata,   32'd0);
        checkOutput("rw stray stall", {31'd0, stallreq}, 32'd0);
        checkBusIdle("rw stray");
        tick();
        checkOutput("rw still idle", data_sram_rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule
